// File: rtl/fifo_pop_router_pkg.sv
// Shared definitions for the FIFO pop router: FSM state encodings, the width
// of the class field that selects a destination, and the per-destination
// delivery counter width.
package fifo_pop_router_pkg;

  localparam int CLS_W = 2;
  localparam int CNT_W = 5;

  typedef enum logic [1:0] {
    ST_RESET  = 2'd0,
    ST_INIT   = 2'd1,
    ST_IDLE   = 2'd2,
    ST_ACTIVE = 2'd3
  } state_e;

endpackage

// File: rtl/fifo_pop_router_cnt.sv
// Per-destination delivery counter bank for the FIFO pop router.
// Only compiled when FIFO_POP_ROUTER_CNT_EN is defined, since the top only
// instantiates it in that build.
// Each destination owns a wrapping CNT_W-bit counter that advances on every
// write strobe to that destination. A request taken in IDLE returns the
// selected count on the following cycle together with a one-cycle valid.
`ifdef FIFO_POP_ROUTER_CNT_EN
module fifo_pop_router_cnt
  import fifo_pop_router_pkg::*;
#(
  parameter int NUM_DEST = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_DEST-1:0] dest_wr,
  input  logic                in_idle,
  input  logic                cnt_req,
  input  logic [CLS_W-1:0]    cnt_sel,
  output logic [CNT_W-1:0]    cnt_out,
  output logic                cnt_valid
);

  logic [CNT_W-1:0] cnt_q [NUM_DEST];
  logic [CNT_W-1:0] cnt_d [NUM_DEST];
  logic [CNT_W-1:0] cnt_out_q, cnt_out_d;
  logic             cnt_valid_q, cnt_valid_d;

  // Advance each counter on its strobe; capture the selected count on a request in IDLE.
  always_comb begin
    for (int i = 0; i < NUM_DEST; i++) begin
      cnt_d[i] = cnt_q[i] + CNT_W'(dest_wr[i]);
    end
    cnt_out_d   = cnt_out_q;
    cnt_valid_d = 1'b0;
    if (in_idle && cnt_req) begin
      cnt_valid_d = 1'b1;
      cnt_out_d   = '0;
      for (int i = 0; i < NUM_DEST; i++) begin
        if (int'(cnt_sel) == i) cnt_out_d = cnt_q[i];
      end
    end
  end

  // Counter and readout registers, cleared by synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_DEST; i++) cnt_q[i] <= '0;
      cnt_out_q   <= '0;
      cnt_valid_q <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_DEST; i++) cnt_q[i] <= cnt_d[i];
      cnt_out_q   <= cnt_out_d;
      cnt_valid_q <= cnt_valid_d;
    end
  end

  assign cnt_out   = cnt_out_q;
  assign cnt_valid = cnt_valid_q;

endmodule
`endif

// File: rtl/fifo_pop_router.sv
// FIFO pop router: drains the upstream FIFO whenever it has data and no
// destination is near full, and steers each word to one of NUM_DEST
// destination FIFOs by its class field (top CLS_W bits of the word).
// Also programs the upstream FIFO thresholds while in INIT.
// Optional build macro FIFO_POP_ROUTER_CNT_EN adds per-destination delivery
// counters with a request/readout port.
//
// state  | meaning
// -------+-----------------------------------------------------------
// RESET  | held in reset, all outputs cleared
// INIT   | thresholds track the *_in inputs every cycle
// IDLE   | waiting for the upstream FIFO to become non-empty
// ACTIVE | popping and routing words, one per cycle
module fifo_pop_router
  import fifo_pop_router_pkg::*;
#(
  parameter int WORD_SIZE = 10,
  parameter int PTR       = 3,
  parameter int NUM_DEST  = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 init,
  input  logic [PTR-1:0]       full_threshold_in,
  input  logic [PTR-1:0]       empty_threshold_in,
  output logic [PTR-1:0]       full_threshold,
  output logic [PTR-1:0]       empty_threshold,
  input  logic                 fifo_empty,
  input  logic                 fifo_error,
  input  logic [WORD_SIZE-1:0] fifo_data_out,
  output logic                 fifo_rd,
  input  logic [NUM_DEST-1:0]  dest_almost_full,
  output logic [NUM_DEST-1:0]  dest_wr,
  output logic [WORD_SIZE-1:0] dest_data,
  output logic [1:0]           state,
  output logic                 idle,
  output logic                 error_out
`ifdef FIFO_POP_ROUTER_CNT_EN
  ,
  input  logic                 cnt_req,
  input  logic [CLS_W-1:0]     cnt_sel,
  output logic [CNT_W-1:0]     cnt_out,
  output logic                 cnt_valid
`endif
);

  state_e               state_q, state_d;
  logic                 rd_q, rd_d;
  logic [NUM_DEST-1:0]  dest_wr_q, dest_wr_d;
  logic [WORD_SIZE-1:0] dest_data_q, dest_data_d;
  logic [PTR-1:0]       full_thr_q, full_thr_d;
  logic [PTR-1:0]       empty_thr_q, empty_thr_d;
  logic                 error_q, error_d;

  logic [CLS_W-1:0]     cls;
  logic [NUM_DEST-1:0]  cls_onehot;
  logic                 pop;

  assign cls = fifo_data_out[WORD_SIZE-1 -: CLS_W];

  // Class field to one-hot destination; an out-of-range class decodes to all zeros.
  always_comb begin
    cls_onehot = '0;
    for (int i = 0; i < NUM_DEST; i++) begin
      if (int'(cls) == i) cls_onehot[i] = 1'b1;
    end
  end

  // Pop only when every destination can absorb the two words that may still be in flight.
  assign pop = (state_q == ST_ACTIVE) && !fifo_empty && !(|dest_almost_full) && !init;

  // Next-state logic; init always wins, and ACTIVE only goes idle once the pipeline is empty.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RESET:  state_d = ST_INIT;
      ST_INIT:   if (!init) state_d = ST_IDLE;
      ST_IDLE: begin
        if (init)             state_d = ST_INIT;
        else if (!fifo_empty) state_d = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (init)                    state_d = ST_INIT;
        else if (fifo_empty && !rd_q) state_d = ST_IDLE;
      end
      default:   state_d = ST_RESET;
    endcase
  end

  // Datapath: read data lands one cycle after the pop and is registered toward the destination.
  always_comb begin
    rd_d        = pop;
    dest_wr_d   = rd_q ? cls_onehot : '0;
    dest_data_d = rd_q ? fifo_data_out : dest_data_q;
    full_thr_d  = (state_q == ST_INIT) ? full_threshold_in  : full_thr_q;
    empty_thr_d = (state_q == ST_INIT) ? empty_threshold_in : empty_thr_q;
    error_d     = error_q | fifo_error | (rd_q & ~(|cls_onehot));
  end

  // State and datapath registers; reset also drops any write due on the next cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_RESET;
      rd_q        <= 1'b0;
      dest_wr_q   <= '0;
      dest_data_q <= '0;
      full_thr_q  <= '0;
      empty_thr_q <= '0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_q        <= rd_d;
      dest_wr_q   <= dest_wr_d;
      dest_data_q <= dest_data_d;
      full_thr_q  <= full_thr_d;
      empty_thr_q <= empty_thr_d;
      error_q     <= error_d;
    end
  end

  assign fifo_rd         = pop;
  assign dest_wr         = dest_wr_q;
  assign dest_data       = dest_data_q;
  assign full_threshold  = full_thr_q;
  assign empty_threshold = empty_thr_q;
  assign state           = state_q;
  assign idle            = (state_q == ST_IDLE);
  assign error_out       = error_q;

`ifdef FIFO_POP_ROUTER_CNT_EN
  fifo_pop_router_cnt #(
    .NUM_DEST (NUM_DEST)
  ) u_cnt (
    .clk       (clk),
    .reset     (reset),
    .dest_wr   (dest_wr_q),
    .in_idle   (state_q == ST_IDLE),
    .cnt_req   (cnt_req),
    .cnt_sel   (cnt_sel),
    .cnt_out   (cnt_out),
    .cnt_valid (cnt_valid)
  );
`endif

endmodule

// File: tb/tb_fifo_pop_router.sv
// Directed testbench for fifo_pop_router. A simple upstream FIFO model feeds
// words on fifo_rd; delivered words are logged on each dest_wr pulse.
module tb_fifo_pop_router;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, init;
  logic [2:0] fth_in, eth_in, full_threshold, empty_threshold;
  logic       fifo_empty, fifo_error, fifo_rd;
  logic [9:0] fifo_data_out, dest_data;
  logic [3:0] dest_af, dest_wr;
  logic [1:0] state;
  logic       idle, error_out;
`ifdef FIFO_POP_ROUTER_CNT_EN
  logic       cnt_req, cnt_valid;
  logic [1:0] cnt_sel;
  logic [4:0] cnt_out;
`endif

  int checks = 0;
  int errors = 0;

  logic [9:0] mem [0:63];
  int         wr_idx = 0;
  int         rd_idx = 0;
  logic [9:0] log_data [0:63];
  logic [3:0] log_wr   [0:63];
  int         log_n = 0;
  int         base, rd_base, at_raise;

  fifo_pop_router dut (
    .clk                (clk),
    .reset              (reset),
    .init               (init),
    .full_threshold_in  (fth_in),
    .empty_threshold_in (eth_in),
    .full_threshold     (full_threshold),
    .empty_threshold    (empty_threshold),
    .fifo_empty         (fifo_empty),
    .fifo_error         (fifo_error),
    .fifo_data_out      (fifo_data_out),
    .fifo_rd            (fifo_rd),
    .dest_almost_full   (dest_af),
    .dest_wr            (dest_wr),
    .dest_data          (dest_data),
    .state              (state),
    .idle               (idle),
    .error_out          (error_out)
`ifdef FIFO_POP_ROUTER_CNT_EN
    ,
    .cnt_req            (cnt_req),
    .cnt_sel            (cnt_sel),
    .cnt_out            (cnt_out),
    .cnt_valid          (cnt_valid)
`endif
  );

  // Upstream FIFO model: read data appears the cycle after a pop.
  assign fifo_empty = (rd_idx == wr_idx);
  always @(posedge clk) begin
    if (fifo_rd) begin
      fifo_data_out <= mem[rd_idx];
      rd_idx        <= rd_idx + 1;
    end
  end

  // Delivery log, one entry per write strobe.
  always @(negedge clk) begin
    if (dest_wr != 4'b0) begin
      log_data[log_n] = dest_data;
      log_wr[log_n]   = dest_wr;
      log_n           = log_n + 1;
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic push(input logic [9:0] w);
    mem[wr_idx] = w;
    wr_idx      = wr_idx + 1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_drain(input string tag, input int max);
    int n = 0;
    while (!(state == 2'd2 && fifo_empty && dest_wr == 4'b0) && n < max) begin
      step();
      n++;
    end
    chk(tag, 32'(n < max), 32'd1);
  endtask

  initial begin
    reset = 1'b1; init = 1'b0; fth_in = 3'd0; eth_in = 3'd0;
    fifo_error = 1'b0; dest_af = 4'b0;
`ifdef FIFO_POP_ROUTER_CNT_EN
    cnt_req = 1'b0; cnt_sel = 2'd0;
`endif

    // 1: reset, INIT with thresholds 6/1, then IDLE
    step(); step();
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_dest_wr", 32'(dest_wr), 32'd0);
    chk("rst_dest_data", 32'(dest_data), 32'd0);
    chk("rst_full_thr", 32'(full_threshold), 32'd0);
    chk("rst_empty_thr", 32'(empty_threshold), 32'd0);
    chk("rst_error", 32'(error_out), 32'd0);
    chk("rst_fifo_rd", 32'(fifo_rd), 32'd0);
    reset = 1'b0; init = 1'b1; fth_in = 3'd6; eth_in = 3'd1;
    step();
    chk("init_state", 32'(state), 32'd1);
    step();
    chk("init_full_thr", 32'(full_threshold), 32'd6);
    chk("init_empty_thr", 32'(empty_threshold), 32'd1);
    init = 1'b0;
    step();
    chk("idle_state", 32'(state), 32'd2);
    chk("idle_flag", 32'(idle), 32'd1);
    chk("idle_dest_wr", 32'(dest_wr), 32'd0);
    fth_in = 3'd3; eth_in = 3'd4;
    step();
    chk("hold_full_thr", 32'(full_threshold), 32'd6);
    chk("hold_empty_thr", 32'(empty_threshold), 32'd1);

    // 2: three words of classes 0, 2, 3
    base = log_n;
    push(10'h0FF); push(10'h2B3); push(10'h3B7);
    step();
    chk("t2_active", 32'(state), 32'd3);
    chk("t2_rd0", 32'(fifo_rd), 32'd1);
    step();
    chk("t2_rd1", 32'(fifo_rd), 32'd1);
    chk("t2_wr_none", 32'(dest_wr), 32'd0);
    step();
    chk("t2_rd2", 32'(fifo_rd), 32'd1);
    chk("t2_wr0", 32'(dest_wr), 32'h1);
    chk("t2_data0", 32'(dest_data), 32'h0FF);
    step();
    chk("t2_rd_off", 32'(fifo_rd), 32'd0);
    chk("t2_wr1", 32'(dest_wr), 32'h4);
    chk("t2_data1", 32'(dest_data), 32'h2B3);
    step();
    chk("t2_wr2", 32'(dest_wr), 32'h8);
    chk("t2_data2", 32'(dest_data), 32'h3B7);
    chk("t2_still_active", 32'(state), 32'd3);
    step();
    chk("t2_back_idle", 32'(state), 32'd2);
    chk("t2_wr_done", 32'(dest_wr), 32'd0);
    chk("t2_count", 32'(log_n - base), 32'd3);

    // 3: stream of 8 class-1 words with backpressure after the second pop
    base = log_n; rd_base = rd_idx;
    for (int i = 0; i < 8; i++) push(10'h101 + 10'(i));
    step();
    chk("t3_rd0", 32'(fifo_rd), 32'd1);
    step();
    chk("t3_rd1", 32'(fifo_rd), 32'd1);
    step();
    dest_af = 4'b0010;
    #1;
    chk("t3_af_block", 32'(fifo_rd), 32'd0);
    at_raise = log_n - base;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("t3_af_hold", 32'(fifo_rd), 32'd0);
    end
    chk("t3_popped", 32'(rd_idx - rd_base), 32'd2);
    chk("t3_inflight_le2", 32'((log_n - base - at_raise) <= 2), 32'd1);
    dest_af = 4'b0;
    wait_drain("t3_drain", 60);
    chk("t3_count", 32'(log_n - base), 32'd8);
    for (int i = 0; i < 8; i++) begin
      chk("t3_data", 32'(log_data[base + i]), 32'h101 + 32'(i));
      chk("t3_wr", 32'(log_wr[base + i]), 32'h2);
    end

    // 4: init while one word is in flight
    base = log_n;
    push(10'h2C1); push(10'h2C2);
    step();
    chk("t4_rd", 32'(fifo_rd), 32'd1);
    step();
    init = 1'b1; fth_in = 3'd5; eth_in = 3'd2;
    #1;
    chk("t4_init_block", 32'(fifo_rd), 32'd0);
    step();
    chk("t4_state_init", 32'(state), 32'd1);
    chk("t4_wr_inflight", 32'(dest_wr), 32'h4);
    chk("t4_data_inflight", 32'(dest_data), 32'h2C1);
    step();
    chk("t4_full_thr", 32'(full_threshold), 32'd5);
    chk("t4_empty_thr", 32'(empty_threshold), 32'd2);
    chk("t4_wr_off", 32'(dest_wr), 32'd0);
    init = 1'b0;
    wait_drain("t4_drain", 30);
    chk("t4_count", 32'(log_n - base), 32'd2);
    chk("t4_first", 32'(log_data[base]), 32'h2C1);
    chk("t4_second", 32'(log_data[base + 1]), 32'h2C2);

    // 5: sticky error, then reset with a write pending
    fifo_error = 1'b1;
    step();
    fifo_error = 1'b0;
    chk("t5_err_set", 32'(error_out), 32'd1);
    step(); step(); step();
    chk("t5_err_sticky", 32'(error_out), 32'd1);
    push(10'h3AA);
    step();
    chk("t5_rd", 32'(fifo_rd), 32'd1);
    step();
    reset = 1'b1;
    base = log_n;
    step();
    chk("t5_rst_state", 32'(state), 32'd0);
    chk("t5_rst_wr", 32'(dest_wr), 32'd0);
    chk("t5_rst_err", 32'(error_out), 32'd0);
    chk("t5_rst_thr", 32'(full_threshold), 32'd0);
    step();
    chk("t5_rst_wr2", 32'(dest_wr), 32'd0);
    chk("t5_no_delivery", 32'(log_n - base), 32'd0);
    reset = 1'b0; init = 1'b1; fth_in = 3'd2; eth_in = 3'd0;
    step(); step();
    init = 1'b0;
    step();
    chk("t5_reinit_idle", 32'(state), 32'd2);

`ifdef FIFO_POP_ROUTER_CNT_EN
    // 6: 33 writes to destination 2 wrap its counter to 1
    base = log_n;
    for (int i = 0; i < 33; i++) push(10'h200 + 10'(i));
    wait_drain("t6_drain", 120);
    chk("t6_count", 32'(log_n - base), 32'd33);
    cnt_req = 1'b1; cnt_sel = 2'd2;
    step();
    cnt_req = 1'b0;
    chk("t6_cnt_valid", 32'(cnt_valid), 32'd1);
    chk("t6_cnt_out", 32'(cnt_out), 32'd1);
    step();
    chk("t6_valid_pulse", 32'(cnt_valid), 32'd0);
    cnt_req = 1'b1; cnt_sel = 2'd3;
    step();
    cnt_req = 1'b0;
    chk("t6_cnt3", 32'(cnt_out), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_pop_router.md
Name: fifo_pop_router

Overview:
- Downstream consumer of the 8x10 FIFO: pops words whenever the FIFO is non-empty and all destination FIFOs have room.
- Routes each word to one of 4 destination FIFOs by its class field (data[9:8]).
- Also owns threshold programming: drives full_threshold/empty_threshold into the FIFO during INIT.

Parameters:
WORD_SIZE, 10, word width
PTR, 3, FIFO pointer/threshold width
NUM_DEST, 4, destination count; class field width = 2 = log2(NUM_DEST), taken from data[WORD_SIZE-1:WORD_SIZE-2]

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
init  in  1  hold high to (re)load thresholds
full_threshold_in  in  PTR  threshold value latched in INIT
empty_threshold_in  in  PTR  threshold value latched in INIT
full_threshold  out  PTR  to FIFO
empty_threshold  out  PTR  to FIFO
fifo_empty  in  1  upstream FIFO empty
fifo_error  in  1  upstream FIFO error
fifo_data_out  in  WORD_SIZE  upstream read data, valid the cycle after fifo_rd
fifo_rd  out  1  pop request (combinational)
dest_almost_full  in  NUM_DEST  per-destination backpressure
dest_wr  out  NUM_DEST  one-hot write strobe (registered)
dest_data  out  WORD_SIZE  routed word (registered)
state  out  2  current FSM state
idle  out  1  high in IDLE
error_out  out  1  sticky error

Behaviour:
- Reset, sampled on posedge clk while reset=1:
  - state=RESET.
  - All outputs 0: fifo_rd, dest_wr, dest_data, thresholds, error_out.
  - In-flight flag cleared.
- FSM states: RESET=0, INIT=1, IDLE=2, ACTIVE=3.
  - RESET -> INIT on the first cycle with reset=0.
  - INIT:
    - Every cycle, full_threshold<=full_threshold_in and empty_threshold<=empty_threshold_in.
    - Stays in INIT while init=1; -> IDLE when init=0.
  - IDLE:
    - init=1 -> INIT.
    - Otherwise, fifo_empty=0 -> ACTIVE; else stay.
  - ACTIVE:
    - init=1 -> INIT (priority).
    - Else -> IDLE when fifo_empty=1 and no word is in flight.
- Pop rule: fifo_rd = (state==ACTIVE) & ~fifo_empty & ~|dest_almost_full & ~init.
- Pipeline:
  - Cycle N: fifo_rd=1.
  - N+1: data is on fifo_data_out; flag rd_q=1.
  - End of N+1: dest_data<=fifo_data_out; dest_wr<=onehot(fifo_data_out[9:8]).
  - N+2: dest_wr is high for exactly 1 cycle. Sustained throughput is 1 word/cycle.
- Backpressure: up to 2 words may be in flight after any almost_full rises. Destination FIFOs must set their almost-full margin >= 2.
- In-flight words are always delivered, including across an ACTIVE->INIT transition. Reset drops them.
- error_out:
  - Set when fifo_error=1, or when rd_q=1 while the word's class is out of range (only possible if NUM_DEST < 4).
  - Sticky until reset.
- Thresholds hold their values outside INIT.
- Mid-operation reset:
  - Everything returns to reset values on the next edge.
  - Any dest_wr pending for the next cycle is suppressed.

Optional Feature:
- Macro: FIFO_POP_ROUTER_CNT_EN.
- When defined, adds these ports:
  - cnt_req  in  1
  - cnt_sel  in  2
  - cnt_out  out  5
  - cnt_valid  out  1
- Counter behaviour:
  - One 5-bit wrapping counter per destination, incremented on each dest_wr of that destination.
  - Counters clear on reset.
  - cnt_req=1 in IDLE -> next cycle cnt_out=count[cnt_sel], cnt_valid=1 for 1 cycle.
  - cnt_req is ignored outside IDLE.
- When undefined, the ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- Package fifo_pop_router_pkg: state encodings (RESET/INIT/IDLE/ACTIVE), class-field width, counter width 5.
- Sub-module fifo_pop_router_cnt: the per-destination counter bank, instantiated only under FIFO_POP_ROUTER_CNT_EN.

Test Plan:
1. Reset high for 2 cycles, then low with init=1, full_threshold_in=6, empty_threshold_in=1, then init=0 -> state RESET->INIT->IDLE, thresholds read 6/1, all strobes 0.
2. Preload 3 words with classes 0,2,3 (0x0FF, 0x2B3, 0x3B7), all dest_almost_full=0 -> fifo_rd high for 3 consecutive cycles; dest_wr=0001,0100,1000 with matching dest_data at N+2..N+4; state returns to IDLE.
3. Stream 8 words and raise dest_almost_full[1] after the 2nd pop -> at most 2 more words delivered, then fifo_rd=0 until it drops; no word lost or duplicated.
4. Assert init mid-stream while one word is in flight -> that word is still written to its destination; state=INIT; thresholds reload.
5. Pulse fifo_error for 1 cycle -> error_out=1 and stays 1 until reset.
6. With FIFO_POP_ROUTER_CNT_EN: write 33 words to destination 2, then cnt_req=1, cnt_sel=2 in IDLE -> cnt_out=1 (wrapped), cnt_valid pulse of 1 cycle.
